// File: rtl/adder_pkg.sv
// Shared types and constants for the adder_32 datapath adder.
// The overflow rule lives here so every consumer uses the same definition.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic cout;
    logic ovf;
  } adder_flags_t;

  // Signed overflow: both operands share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_32_cla4.sv
// 4-bit carry-lookahead slice: local sum plus group propagate/generate for the
// second-level carry network in adder_32.
module cla4
  import adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flat lookahead carries inside the slice; G/P do not depend on ci.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;
  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/adder_32.sv
// Two-level carry-lookahead adder with a combinational result and an optional
// one-cycle registered copy, built only when ADDER_REG_OUT_EN is defined.
module adder_32
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  localparam int NSLICE = WIDTH / 4;

  logic [NSLICE-1:0] grp_p;
  logic [NSLICE-1:0] grp_g;
  logic [NSLICE:0]   carry;
  adder_flags_t      flags;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla4 u_cla4 (
      .a  (a[4*i +: 4]),
      .b  (b[4*i +: 4]),
      .ci (carry[i]),
      .s  (sum[4*i +: 4]),
      .P  (grp_p[i]),
      .G  (grp_g[i])
    );
  end

  // Second-level lookahead: each slice carry is a flat sum of products of the
  // group generate/propagate terms below it and cin.
  always_comb begin
    logic term;
    logic prop;
    carry[0] = cin;
    for (int i = 0; i < NSLICE; i++) begin
      term = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (grp_g[j] & prop);
        prop = prop & grp_p[j];
      end
      carry[i+1] = term | (prop & cin);
    end
  end

  assign flags.cout = carry[NSLICE];
  assign flags.ovf  = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
  assign cout       = flags.cout;
  assign ovf        = flags.ovf;

`ifdef ADDER_REG_OUT_EN
  // Capture stage: results load only on valid, out_valid follows in_valid every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= {WIDTH{1'b0}};
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= flags.cout;
        ovf_q  <= flags.ovf;
      end else begin
        sum_q  <= sum_q;
        cout_q <= cout_q;
        ovf_q  <= ovf_q;
      end
    end
  end
`else
  logic unused_reg_inputs;
  assign unused_reg_inputs = ^{clk, reset, in_valid};

  assign sum_q     = {WIDTH{1'b0}};
  assign cout_q    = 1'b0;
  assign ovf_q     = 1'b0;
  assign out_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adder_32.sv
// Directed self-checking bench for adder_32; registered-stage checks follow
// the ADDER_REG_OUT_EN build option.
module tb_adder_32;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        in_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        out_valid;

  int n_cmp;
  int n_bad;

  adder_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got %h/%b/%b/%b want 0/0/0/0", sum_q, cout_q, ovf_q, out_valid);
    end
    n_cmp++;
    if ({sum, cout, ovf} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_comb_zero: got sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, ovf);
    end
  endtask

  task automatic test_comb();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic        vc [9];
    logic [31:0] es [9];
    logic        eco [9];
    logic        eov [9];
    va[0] = 32'd1;          vb[0] = 32'd1;          vc[0] = 1'b0; es[0] = 32'd2;          eco[0] = 1'b0; eov[0] = 1'b0;
    va[1] = 32'd4;          vb[1] = 32'd12;         vc[1] = 1'b0; es[1] = 32'd16;         eco[1] = 1'b0; eov[1] = 1'b0;
    va[2] = 32'd19239859;   vb[2] = 32'd5435932;    vc[2] = 1'b0; es[2] = 32'd24675791;   eco[2] = 1'b0; eov[2] = 1'b0;
    va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd1;          vc[3] = 1'b0; es[3] = 32'd0;          eco[3] = 1'b1; eov[3] = 1'b0;
    va[4] = 32'h7FFF_FFFF;  vb[4] = 32'd1;          vc[4] = 1'b0; es[4] = 32'h8000_0000;  eco[4] = 1'b0; eov[4] = 1'b1;
    va[5] = 32'h8000_0000;  vb[5] = 32'h8000_0000;  vc[5] = 1'b0; es[5] = 32'd0;          eco[5] = 1'b1; eov[5] = 1'b1;
    va[6] = 32'd5;          vb[6] = 32'hFFFF_FFFD;  vc[6] = 1'b1; es[6] = 32'd3;          eco[6] = 1'b1; eov[6] = 1'b0;
    va[7] = 32'h0000_FFFF;  vb[7] = 32'h0000_0000;  vc[7] = 1'b1; es[7] = 32'h0001_0000;  eco[7] = 1'b0; eov[7] = 1'b0;
    va[8] = 32'hFFFF_FFFF;  vb[8] = 32'hFFFF_FFFF;  vc[8] = 1'b1; es[8] = 32'hFFFF_FFFF;  eco[8] = 1'b1; eov[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = va[i];
      b = vb[i];
      cin = vc[i];
      #1;
      n_cmp++;
      if ({sum, cout, ovf} !== {es[i], eco[i], eov[i]}) begin
        n_bad++;
        $display("FAIL comb_vec%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], eco[i], eov[i]);
      end
    end
  endtask

`ifdef ADDER_REG_OUT_EN
  task automatic test_registered();
    @(negedge clk);
    a = 32'd10; b = 32'd20; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== {32'd30, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reg_capture: got %0d/%b/%b/%b want 30/0/0/1", sum_q, cout_q, ovf_q, out_valid);
    end
    @(negedge clk);
    a = 32'd7; b = 32'd8; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, out_valid} !== {32'd30, 1'b0}) begin
      n_bad++;
      $display("FAIL reg_hold: got sum_q=%0d out_valid=%b want 30/0", sum_q, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== {32'd0, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_flags: got %h/%b/%b/%b want 0/1/1/1", sum_q, cout_q, ovf_q, out_valid);
    end
    @(negedge clk);
    a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== {32'd2, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_next: got %h/%b/%b/%b want 2/0/0/1", sum_q, cout_q, ovf_q, out_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #2;
    a = 32'd3; b = 32'd4;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== 35'd0) begin
      n_bad++;
      $display("FAIL async_reset_clear: got %h/%b/%b/%b want 0/0/0/0", sum_q, cout_q, ovf_q, out_valid);
    end
    n_cmp++;
    if (sum !== 32'd7) begin
      n_bad++;
      $display("FAIL async_reset_comb: got sum=%0d want 7", sum);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, out_valid} !== {32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_held: got sum_q=%h out_valid=%b want 0/0", sum_q, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, out_valid} !== {32'd30, 1'b1}) begin
      n_bad++;
      $display("FAIL post_reset_capture: got sum_q=%0d out_valid=%b want 30/1", sum_q, out_valid);
    end
  endtask
`else
  task automatic test_no_reg_stage();
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_q, cout_q, ovf_q, out_valid} !== 35'd0) begin
      n_bad++;
      $display("FAIL no_reg_stage: got %h/%b/%b/%b want 0/0/0/0", sum_q, cout_q, ovf_q, out_valid);
    end
    n_cmp++;
    if ({sum, cout} !== {32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL no_reg_comb: got sum=%h cout=%b want 0/1", sum, cout);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a = 32'd0;
    b = 32'd0;
    cin = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_comb();
    @(negedge clk);
    reset = 1'b0;
`ifdef ADDER_REG_OUT_EN
    test_registered();
    test_back_to_back();
    test_async_reset();
`else
    test_no_reg_stage();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
